// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 SRAM slave with independent INCR read and write bursts
module axi_sram_slave #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1c00_0000,
  parameter int          RD_LATENCY  = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT_LAST = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH_WORDS];

  r_state_t    r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_len, r_beat, r_cnt;
  logic [31:0] rd_ld_addr, rd_off, rd_word;
  logic        rd_hit;

  w_state_t    w_state;
  logic [31:0] w_addr, wr_off;
  logic [3:0]  w_len, w_beat;
  logic        w_dec, w_slv, wr_hit, w_fire;

  logic unused_ok;
  assign unused_ok = ^{arsize, arburst, awsize, awburst, arlen[7:4], awlen[7:4],
                       rd_off[31:AW+2], rd_off[1:0], wr_off[31:AW+2], wr_off[1:0]};

  // Address of the beat about to be loaded: the AR address at launch, the latched
  // address after the wait, or the following word when a beat advances.
  always_comb begin
    rd_ld_addr = r_addr + 32'd4;
    if (r_state == R_IDLE)      rd_ld_addr = araddr;
    else if (r_state == R_WAIT) rd_ld_addr = r_addr;
  end

  assign rd_off  = rd_ld_addr - BASE_ADDR;
  assign rd_hit  = rd_off < SPAN;
  assign rd_word = mem[rd_off[AW+1:2]];

  assign wr_off  = w_addr - BASE_ADDR;
  assign wr_hit  = wr_off < SPAN;
  assign w_fire  = (w_state == W_DATA) && wvalid && wready;

  // Byte-masked array write; array contents survive reset.
  always_ff @(posedge aclk) begin
    if (w_fire && wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[wr_off[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read channel FSM: accept AR, wait RD_LATENCY cycles, stream beats under rready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            arready <= 1'b0;
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen[3:0];
            r_beat  <= '0;
            r_cnt   <= '0;
            if (RD_LATENCY == 0) begin
              r_state <= R_DATA;
              rvalid  <= 1'b1;
              rlast   <= (arlen[3:0] == 4'd0);
              rdata   <= rd_hit ? rd_word : 32'd0;
              rresp   <= rd_hit ? 2'b00 : 2'b11;
            end else begin
              r_state <= R_WAIT;
            end
          end else begin
            arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_cnt == LAT_LAST) begin
            r_state <= R_DATA;
            rvalid  <= 1'b1;
            rlast   <= (r_len == 4'd0);
            rdata   <= rd_hit ? rd_word : 32'd0;
            rresp   <= rd_hit ? 2'b00 : 2'b11;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (r_beat == r_len) begin
              r_state <= R_IDLE;
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
            end else begin
              r_addr <= r_addr + 32'd4;
              r_beat <= r_beat + 4'd1;
              rlast  <= ((r_beat + 4'd1) == r_len);
              rdata  <= rd_hit ? rd_word : 32'd0;
              rresp  <= rd_hit ? 2'b00 : 2'b11;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write channel FSM: accept AW, take len+1 beats, then hold the response until bready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_dec   <= 1'b0;
      w_slv   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            bid     <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen[3:0];
            w_beat  <= '0;
            w_dec   <= 1'b0;
            w_slv   <= 1'b0;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= w_addr + 32'd4;
            w_beat <= w_beat + 4'd1;
            w_dec  <= w_dec | ~wr_hit;
            w_slv  <= w_slv | (wlast != (w_beat == w_len));
            if (w_beat == w_len) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              w_state <= W_RESP;
              // Decode errors outrank a wlast mismatch; on the final beat wlast must be set.
              if (w_dec || !wr_hit)      bresp <= 2'b11;
              else if (w_slv || !wlast)  bresp <= 2'b10;
              else                       bresp <= 2'b00;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized model-checked bench for axi_sram_slave
module tb_axi_sram_slave;
  localparam logic [31:0] BASE   = 32'h1c00_0000;
  localparam int          DEPTH  = 1024;
  localparam int          RD_LAT = 1;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = 2'b01;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = 2'b01;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;

  axi_sram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; int nbeats; } bexp_t;

  rbeat_t      exp_r[$];
  rbeat_t      rd_log[$];
  bexp_t       exp_b[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wbuf_d [16];
  logic [3:0]  wbuf_s [16];
  logic        wbuf_l [16];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  bit   bready_rand = 1'b0;
  bit   mon_en = 1'b1;
  logic [3:0] last_bid;
  logic [1:0] last_bresp;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no event, expected one within bound", name);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 5))
      0:       return BASE + 32'(DEPTH * 4) - 32'(4 * $urandom_range(1, 8));
      1:       return BASE - 32'(4 * $urandom_range(1, 8));
      2:       return 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  always @(posedge aclk) cyc++;

  initial begin
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        0: rready = 1'b1;
        1: rready = 1'($urandom);
        2: rready = 1'b0;
        default: rready = ~rready;
      endcase
      bready = bready_rand ? 1'($urandom) : 1'b1;
    end
  end

  // Compare process: R/B channel contents, timing and hold-stability against the model queues.
  int   ar_cyc, last_w_cyc, w_cnt;
  bit   r_first, prev_r_stall, prev_r_cont, w_wait_b;
  logic [38:0] prev_r_bundle;
  always @(negedge aclk) begin
    rbeat_t e;
    bexp_t  be;
    if (!aresetn || !mon_en) begin
      r_first = 0; prev_r_stall = 0; prev_r_cont = 0; w_cnt = 0; w_wait_b = 0;
    end else begin
      if (arvalid && arready) begin ar_cyc = cyc; r_first = 1; end
      if (rvalid && r_first) begin
        chk("r_first_latency", 64'(cyc - ar_cyc), 64'(RD_LAT + 1));
        r_first = 0;
      end
      if (prev_r_cont) chk("r_next_beat_valid", 64'(rvalid), 64'd1);
      if (prev_r_stall) begin
        chk("r_hold_valid", 64'(rvalid), 64'd1);
        chk("r_hold_payload", 64'({rid, rdata, rresp, rlast}), 64'(prev_r_bundle));
      end
      prev_r_stall  = rvalid && !rready;
      prev_r_bundle = {rid, rdata, rresp, rlast};
      prev_r_cont   = 0;
      if (rvalid && rready) begin
        rd_log.push_back('{rid, rdata, rresp, rlast});
        if (exp_r.size() == 0) fail_now("r_unexpected_beat");
        else begin
          e = exp_r.pop_front();
          chk("rid", 64'(rid), 64'(e.id));
          chk("rdata", 64'(rdata), 64'(e.data));
          chk("rresp", 64'(rresp), 64'(e.resp));
          chk("rlast", 64'(rlast), 64'(e.last));
          prev_r_cont = !e.last;
        end
      end
      if (wvalid && wready) begin
        w_cnt++;
        if (exp_b.size() > 0 && w_cnt == exp_b[0].nbeats) begin
          last_w_cyc = cyc; w_wait_b = 1;
        end
      end
      if (w_wait_b && cyc == last_w_cyc + 1) begin
        chk("bvalid_after_last_w", 64'(bvalid), 64'd1);
        chk("wready_drop_after_last_w", 64'(wready), 64'd0);
        w_wait_b = 0;
      end
      if (bvalid && bready) begin
        last_bid = bid; last_bresp = bresp; w_cnt = 0;
        if (exp_b.size() == 0) fail_now("b_unexpected_response");
        else begin
          be = exp_b.pop_front();
          chk("bid", 64'(bid), 64'(be.id));
          chk("bresp", 64'(bresp), 64'(be.resp));
        end
      end
    end
  end

  task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
    int k;
    @(posedge aclk); #1;
    arvalid = 1'b1; arid = id; araddr = a; arlen = l;
    k = 0;
    @(negedge aclk);
    while (!arready && k < 200) begin @(negedge aclk); k++; end
    if (!arready) fail_now("ar_handshake_timeout");
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
    int k;
    @(posedge aclk); #1;
    awvalid = 1'b1; awid = id; awaddr = a; awlen = l;
    k = 0;
    @(negedge aclk);
    while (!awready && k < 200) begin @(negedge aclk); k++; end
    if (!awready) fail_now("aw_handshake_timeout");
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l, input logic [31:0] a);
    int k;
    wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
    k = 0;
    @(negedge aclk);
    while (!wready && k < 200) begin @(negedge aclk); k++; end
    if (!wready) fail_now("w_handshake_timeout");
    else if (in_rng(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
    end
    @(posedge aclk); #1;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
    int k;
    logic [31:0] ba;
    for (int i = 0; i <= int'(l[3:0]); i++) begin
      ba = a + 32'(4 * i);
      if (in_rng(ba)) exp_r.push_back('{id, ref_mem[widx(ba)], 2'b00, i == int'(l[3:0])});
      else            exp_r.push_back('{id, 32'd0, 2'b11, i == int'(l[3:0])});
    end
    ar_send(id, a, l);
    k = 0;
    while (exp_r.size() != 0 && k < 500) begin @(negedge aclk); k++; end
    if (exp_r.size() != 0) begin fail_now("read_burst_timeout"); exp_r.delete(); end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
    int  k, n;
    bit  dec, slv;
    n = int'(l[3:0]) + 1;
    dec = 0; slv = 0;
    for (int i = 0; i < n; i++) begin
      if (!in_rng(a + 32'(4 * i))) dec = 1;
      if (wbuf_l[i] != (i == n - 1)) slv = 1;
    end
    exp_b.push_back('{id, dec ? 2'b11 : (slv ? 2'b10 : 2'b00), n});
    aw_send(id, a, l);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(posedge aclk); #1;
      end
      send_w(wbuf_d[i], wbuf_s[i], wbuf_l[i], a + 32'(4 * i));
    end
    wvalid = 1'b0; wlast = 1'b0;
    k = 0;
    while (exp_b.size() != 0 && k < 500) begin @(negedge aclk); k++; end
    if (exp_b.size() != 0) begin fail_now("write_resp_timeout"); exp_b.delete(); end
  endtask

  task automatic fill_wbuf(input int n, input bit full_strb);
    for (int i = 0; i < 16; i++) begin
      wbuf_d[i] = $urandom;
      wbuf_s[i] = full_strb ? 4'hF : 4'($urandom);
      wbuf_l[i] = (i == n - 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arready"}, 64'(arready), 64'd0);
    chk({tag, "_awready"}, 64'(awready), 64'd0);
    chk({tag, "_wready"},  64'(wready),  64'd0);
    chk({tag, "_rvalid"},  64'(rvalid),  64'd0);
    chk({tag, "_bvalid"},  64'(bvalid),  64'd0);
    chk({tag, "_rpayload"}, 64'({rid, rdata, rresp, rlast}), 64'd0);
    chk({tag, "_bpayload"}, 64'({bid, bresp}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    n_checks++; n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  logic [3:0]  tid, tid2;
  logic [31:0] ta, ta2;
  logic [7:0]  tl, tl2;
  int          j;

  initial begin
    repeat (3) @(negedge aclk);
    check_reset_outputs("por");
    aresetn = 1'b1;
    @(negedge aclk);
    chk("arready_after_release", 64'(arready), 64'd1);
    chk("awready_after_release", 64'(awready), 64'd1);

    // Preload the whole array so every read has a known model value.
    for (int b = 0; b < DEPTH / 16; b++) begin
      fill_wbuf(16, 1'b1);
      do_write(4'(b), BASE + 32'(64 * b), 8'd15);
    end

    // Reset pulse: outputs clear, array retained.
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(negedge aclk);
    check_reset_outputs("pulse");
    aresetn = 1'b1;

    // 1: single-beat read at base.
    rd_log.delete();
    do_read(4'd3, BASE, 8'd0);
    chk("t1_rid", 64'(rd_log[0].id), 64'd3);
    chk("t1_rlast", 64'(rd_log[0].last), 64'd1);
    chk("t1_rresp", 64'(rd_log[0].resp), 64'd0);

    // 2: four-beat write then readback.
    for (int i = 0; i < 4; i++) begin
      wbuf_d[i] = 32'h11 * 32'(i + 1); wbuf_s[i] = 4'hF; wbuf_l[i] = (i == 3);
    end
    do_write(4'd5, BASE + 32'd8, 8'd3);
    chk("t2_bid", 64'(last_bid), 64'd5);
    chk("t2_bresp", 64'(last_bresp), 64'd0);
    rd_log.delete();
    do_read(4'd6, BASE + 32'd8, 8'd3);
    for (int i = 0; i < 4; i++) begin
      chk("t2_rdata", 64'(rd_log[i].data), 64'(32'h11 * 32'(i + 1)));
      chk("t2_rlast", 64'(rd_log[i].last), 64'(i == 3));
    end

    // 3: partial strobe over zero, read with toggling rready.
    wbuf_d[0] = 32'd0; wbuf_s[0] = 4'hF; wbuf_l[0] = 1'b1;
    do_write(4'd1, BASE + 32'h20, 8'd0);
    wbuf_d[0] = 32'hAABB_CCDD; wbuf_s[0] = 4'b0101;
    do_write(4'd2, BASE + 32'h20, 8'd0);
    rdy_mode = 3;
    rd_log.delete();
    do_read(4'd4, BASE + 32'h20, 8'd2);
    chk("t3_masked_word", 64'(rd_log[0].data), 64'h00BB_00DD);
    rdy_mode = 0;

    // 4: burst crossing the array end.
    rd_log.delete();
    do_read(4'd8, BASE + 32'(4 * DEPTH - 4), 8'd1);
    chk("t4_beat0_resp", 64'(rd_log[0].resp), 64'd0);
    chk("t4_beat1_resp", 64'(rd_log[1].resp), 64'd3);
    chk("t4_beat1_data", 64'(rd_log[1].data), 64'd0);
    fill_wbuf(2, 1'b1);
    do_write(4'd9, BASE + 32'(4 * DEPTH - 4), 8'd1);
    chk("t4_bresp_decerr", 64'(last_bresp), 64'd3);

    // 5: early and missing wlast, then concurrent bursts.
    fill_wbuf(2, 1'b1);
    wbuf_l[0] = 1'b1; wbuf_l[1] = 1'b0;
    do_write(4'd10, BASE + 32'h200, 8'd1);
    chk("t5_early_wlast", 64'(last_bresp), 64'd2);
    fill_wbuf(2, 1'b1);
    wbuf_l[1] = 1'b0;
    do_write(4'd11, BASE + 32'h210, 8'd1);
    chk("t5_missing_wlast", 64'(last_bresp), 64'd2);

    rdy_mode = 1; bready_rand = 1'b1;
    for (int it = 0; it < 8; it++) begin
      tid = 4'($urandom); tid2 = 4'($urandom);
      ta  = BASE + 32'(4 * $urandom_range(0, 400));
      ta2 = BASE + 32'(4 * $urandom_range(512, 1000));
      tl  = 8'($urandom_range(0, 15)); tl2 = 8'($urandom_range(0, 15));
      fill_wbuf(int'(tl2) + 1, 1'b0);
      fork
        do_read(tid, ta, tl);
        do_write(tid2, ta2, tl2);
      join
    end

    // Randomized sequential traffic including decode-error and wrap addresses.
    for (int it = 0; it < 40; it++) begin
      tid = 4'($urandom); ta = rnd_addr(); tl = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) do_read(tid, ta, tl);
      else begin
        fill_wbuf(int'(tl) + 1, 1'b0);
        if ($urandom_range(0, 4) == 0) begin
          j = $urandom_range(0, int'(tl));
          wbuf_l[j] = !wbuf_l[j];
        end
        do_write(tid, ta, tl);
      end
    end
    rdy_mode = 0; bready_rand = 1'b0;
    repeat (3) @(negedge aclk);

    // 6: reset in the middle of a read and a write burst.
    mon_en = 1'b0;
    rdy_mode = 2;
    ar_send(4'd7, BASE + 32'h40, 8'd3);
    j = 0;
    while (!rvalid && j < 50) begin @(negedge aclk); j++; end
    chk("t6_rvalid_before_reset", 64'(rvalid), 64'd1);
    aw_send(4'd12, BASE + 32'h100, 8'd3);
    send_w(32'hCAFE_F00D, 4'hF, 1'b0, BASE + 32'h100);
    aresetn = 1'b0;
    #1;
    chk("t6_rvalid_reset", 64'(rvalid), 64'd0);
    chk("t6_wready_reset", 64'(wready), 64'd0);
    chk("t6_bvalid_reset", 64'(bvalid), 64'd0);
    wvalid = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    exp_r.delete(); exp_b.delete();
    rdy_mode = 0;
    mon_en = 1'b1;
    @(negedge aclk);
    chk("t6_arready_after", 64'(arready), 64'd1);
    rd_log.delete();
    do_read(4'd13, BASE + 32'h100, 8'd0);
    chk("t6_retained", 64'(rd_log[0].data), 64'hCAFE_F00D);
    do_read(4'd14, BASE + 32'h40, 8'd3);
    do_read(4'd15, BASE + 32'h8, 8'd3);

    repeat (3) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
